traffic_ctrl_param: RTL

//  Parametrised N-approach intersection controller; next generation of the fixed 4-way controller.

---
 rtl/traffic_pkg.sv | 20 ++
 rtl/rr_next_dir.sv | 22 ++
 rtl/traffic_ctrl_param.sv | 111 +++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: state codes, lamp encodings and width helper shared by the traffic controller and its bench
package traffic_pkg;
   typedef enum logic [2:0] {
      ALLRED = 3'd0,
      GREEN  = 3'd1,
      YELLOW = 3'd2,
      EMG    = 3'd3,
      FLASH  = 3'd4
   } state_e;
   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;
   localparam logic [2:0] OFF = 3'b000;
   function automatic int clog2(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction
endpackage

// File: rtl/rr_next_dir.sv
// rr_next_dir: first requesting approach after cur_dir, cur_dir itself last; plain rotation when idle
module rr_next_dir
   import traffic_pkg::*;
#(
   parameter int N_DIR = 4,
   parameter int DW    = clog2(N_DIR)
) (
   input  logic [N_DIR-1:0] req,
   input  logic [DW-1:0]    cur_dir,
   output logic [DW-1:0]    nxt_dir
);
   logic [DW-1:0] idx;
   always_comb begin
      nxt_dir = DW'((int'(cur_dir) + 1) % N_DIR);
      idx = '0;
      // scan far-to-near so the nearest requester after cur_dir is the last write
      for (int k = N_DIR; k >= 1; k--) begin
         idx = DW'((int'(cur_dir) + k) % N_DIR);
         if (req[idx]) nxt_dir = idx;
      end
   end
endmodule

// File: rtl/traffic_ctrl_param.sv
// traffic_ctrl_param: N-approach round-robin intersection controller with emergency pre-emption and flash mode
module traffic_ctrl_param
   import traffic_pkg::*;
#(
   parameter int N_DIR      = 4,
   parameter int GREEN_CYC  = 8,
   parameter int YELLOW_CYC = 3,
   parameter int ALLRED_CYC = 2,
   parameter int FLASH_HALF = 4,
   parameter int CNT_W      = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [N_DIR-1:0]          req,
   input  logic                      emg_vld,
   input  logic [clog2(N_DIR)-1:0]   emg_dir,
   input  logic                      flash_mode,
   output logic [3*N_DIR-1:0]        lights,
   output logic [clog2(N_DIR)-1:0]   cur_dir,
   output logic [2:0]                st
);
   localparam int DW = clog2(N_DIR);
   localparam logic [DW:0]      N_LIM = (DW+1)'(N_DIR);
   localparam logic [CNT_W-1:0] T_GRN = CNT_W'(GREEN_CYC - 1);
   localparam logic [CNT_W-1:0] T_YEL = CNT_W'(YELLOW_CYC - 1);
   localparam logic [CNT_W-1:0] T_RED = CNT_W'(ALLRED_CYC - 1);
   localparam logic [CNT_W-1:0] T_FL  = CNT_W'(FLASH_HALF - 1);
   state_e             st_q, st_d;
   logic [DW-1:0]      cur_q, cur_d, rr_dir;
   logic [CNT_W-1:0]   tmr_q, tmr_d;
   logic               flash_on_q, flash_on_d;
   logic [3*N_DIR-1:0] lights_q, lights_d;
   logic               emg_ok, tmr_end;

   rr_next_dir #(.N_DIR(N_DIR), .DW(DW)) u_rr (
      .req     (req),
      .cur_dir (cur_q),
      .nxt_dir (rr_dir)
   );

   assign emg_ok  = emg_vld && ({1'b0, emg_dir} < N_LIM);
   assign tmr_end = tmr_q == '0;

   always_comb begin
      st_d       = st_q;
      cur_d      = cur_q;
      tmr_d      = tmr_end ? '0 : tmr_q - 1'b1;
      flash_on_d = flash_on_q;
      if (!en) begin
         tmr_d = tmr_q;
      end else if (flash_mode) begin
         st_d       = FLASH;
         tmr_d      = (st_q != FLASH || tmr_end) ? T_FL : tmr_q - 1'b1;
         flash_on_d = st_q != FLASH ? 1'b1 : tmr_end ? !flash_on_q : flash_on_q;
      end else begin
         case (st_q)
            ALLRED: if (tmr_end) begin
               st_d  = emg_ok ? EMG : GREEN;
               cur_d = emg_ok ? emg_dir : rr_dir;
               tmr_d = T_GRN;
            end
            GREEN: if (emg_ok && emg_dir == cur_q) begin
               st_d = EMG;
            end else if (emg_ok || tmr_end) begin
               st_d  = YELLOW;
               tmr_d = T_YEL;
            end
            YELLOW: if (tmr_end) begin
               st_d  = ALLRED;
               tmr_d = T_RED;
            end
            EMG: if (!emg_ok || emg_dir != cur_q) begin
               st_d  = YELLOW;
               tmr_d = T_YEL;
            end
            default: begin
               st_d  = ALLRED;
               tmr_d = T_RED;
            end
         endcase
      end
   end

   // lamps are decoded from next-state values and registered, so outputs are glitch-free flops
   for (genvar i = 0; i < N_DIR; i++) begin : g_lamp
      assign lights_d[3*i +: 3] = st_d == FLASH ? (flash_on_d ? YEL : OFF)
                                : (st_d == ALLRED || cur_d != DW'(i)) ? RED
                                : st_d == YELLOW ? YEL : GRN;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q       <= ALLRED;
         cur_q      <= '0;
         tmr_q      <= T_RED;
         flash_on_q <= 1'b1;
         lights_q   <= {N_DIR{RED}};
      end else begin
         st_q       <= st_d;
         cur_q      <= cur_d;
         tmr_q      <= tmr_d;
         flash_on_q <= flash_on_d;
         lights_q   <= lights_d;
      end
   end

   assign lights  = lights_q;
   assign cur_dir = cur_q;
   assign st      = st_q;
endmodule
